pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the payload width in bits (legal range 1..256).
REQ-002 Parameter CLEAR_ON_FLUSH, default 1, SHALL select whether flush also zeroes the stored payload registers (1) or leaves them unchanged (0).
REQ-003 Port list, one per line:
- clk  in  1  single clock; all state SHALL update on its rising edge.
- rst  in  1  reset, synchronous and active-low: sampled on the rising edge of clk, and rst=0 resets the block.
- flush  in  1  drop all held entries.
- in_valid  in  1  upstream payload valid.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  block can accept this cycle.
- out_valid  out  1  downstream payload valid.
- out_data  out  WIDTH  downstream payload.
- out_ready  in  1  downstream accepts this cycle.
- count  out  2  entries held (0..2).

Function
REQ-004 The block SHALL be a 2-entry skid buffer made of a main register (drives out_data) and a skid register; the state is EMPTY (count=0), ONE (count=1) or FULL (count=2).
REQ-005 in_ready SHALL be driven only from registered state: 1 in EMPTY and ONE, 0 in FULL; there SHALL be no combinational path from out_ready to in_ready.
REQ-006 out_valid SHALL be 1 exactly when count is at least 1, and out_data SHALL always equal the main register.
REQ-007 Accept (in_fire) SHALL equal in_valid AND in_ready; drain (out_fire) SHALL equal out_valid AND out_ready.
REQ-008 Transitions out of EMPTY: in_fire SHALL load main and go to ONE; otherwise the state SHALL hold.
REQ-009 Transitions out of ONE:
- in_fire and out_fire: load main with in_data and stay in ONE.
- in_fire only: load skid with in_data and go to FULL, leaving main unchanged.
- out_fire only: go to EMPTY.
- neither: hold.
REQ-010 Transitions out of FULL: out_fire SHALL copy skid into main and go to ONE; otherwise the state SHALL hold. in_valid SHALL be ignored in FULL.
REQ-011 Latency SHALL be one cycle: data accepted at edge N SHALL appear on out_data with out_valid=1 after edge N when the block was EMPTY or draining in ONE.
REQ-012 Ordering SHALL be strict FIFO; no payload SHALL be dropped or duplicated except by flush or reset.
REQ-013 While out_valid=1 and out_ready=0, out_data SHALL stay stable.
REQ-014 flush=1 at an edge SHALL force EMPTY and SHALL override any simultaneous in_fire or out_fire, so the same-cycle input is discarded.
REQ-015 Flush payload behaviour: with CLEAR_ON_FLUSH=1, flush SHALL zero main and skid; with CLEAR_ON_FLUSH=0, their contents SHALL stay unchanged.
REQ-016 Because in_ready=1 whenever the block is not FULL, flush in EMPTY or ONE SHALL still present in_ready=1 in that cycle, but the accepted beat SHALL be discarded per REQ-014.
REQ-017 count SHALL be registered and SHALL match the state encoding exactly.
REQ-018 The design SHALL contain no latches, and its only sequential element clock SHALL be clk.

Reset
REQ-019 rst=0 at a rising edge SHALL force, after that edge: EMPTY, count=0, out_valid=0, in_ready=1, main=0 and skid=0.
REQ-020 Reset SHALL take priority over flush and over all handshakes; reset in the middle of operation SHALL discard held entries.
REQ-021 Once rst=1, the first rising edge SHALL operate normally.

Verification
REQ-022 Pass-through: out_ready held at 1; send 0xA1, 0xA2, 0xA3 on consecutive cycles -> each appears one cycle later, count stays 1, and in_ready stays 1.
REQ-023 Backpressure: out_ready=0; send 0xB1, then 0xB2 -> count=2 and in_ready=0; 0xB3 is held off; raise out_ready -> outputs 0xB1, 0xB2, 0xB3 in order, with 0xB3 accepted once in_ready returns to 1.
REQ-024 Flush in FULL (0xC1, 0xC2 held) with a simultaneous out_ready=1 -> next cycle count=0 and out_valid=0; with CLEAR_ON_FLUSH=1, out_data=0.
REQ-025 Simultaneous fire in ONE (main=0xD1; in_data=0xD2; both handshakes fire) -> next cycle out_data=0xD2 and count=1.
REQ-026 Reset mid-operation: FULL with 0xE1, 0xE2; drive rst=0 for one edge -> count=0, out_valid=0, in_ready=1, out_data=0; then send 0xE3 -> it is the first output.
REQ-027 Random stress: random in_valid and out_ready for 10k cycles at WIDTH=8 and WIDTH=128 -> scoreboard matches in order, in_ready is never 1 when count=2, and out_data is stable under stall.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer pipeline stage. in_ready depends only on registered
// state, so out_ready never reaches in_ready combinationally.
module pipe_stage_buf #(
    parameter int WIDTH          = 64,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       count_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid_q && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign count     = count_q;

    // Handshake flags and count are registered alongside the state so every
    // output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= EMPTY;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            if (CLEAR_ON_FLUSH) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q      <= in_data;
                        state       <= ONE;
                        count_q     <= 2'd1;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        // Main keeps the older beat; the newer one waits in skid.
                        skid_q     <= in_data;
                        state      <= FULL;
                        count_q    <= 2'd2;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        count_q     <= 2'd0;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state      <= ONE;
                        count_q    <= 2'd1;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    count_q     <= 2'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: WIDTH=8 (clearing flush) and WIDTH=128 (non-clearing
// flush) instances share control inputs and are checked against a queue model.
module tb_pipe_stage_buf;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;

    logic         in_ready8, out_valid8;
    logic [7:0]   out_data8;
    logic [1:0]   count8;
    logic         in_ready128, out_valid128;
    logic [127:0] out_data128;
    logic [1:0]   count128;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] q[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(8), .CLEAR_ON_FLUSH(1'b1)) dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[7:0]), .in_ready(in_ready8),
        .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready),
        .count(count8)
    );

    pipe_stage_buf #(.WIDTH(128), .CLEAR_ON_FLUSH(1'b0)) dut128 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready128),
        .out_valid(out_valid128), .out_data(out_data128), .out_ready(out_ready),
        .count(count128)
    );

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both instances with what the queue model says they should hold.
    task automatic check_model();
        logic [1:0] n;
        n = 2'(q.size());
        check("count8", {126'd0, count8}, {126'd0, n});
        check("count128", {126'd0, count128}, {126'd0, n});
        check("in_ready8", {127'd0, in_ready8}, {127'd0, (q.size() < 2)});
        check("in_ready128", {127'd0, in_ready128}, {127'd0, (q.size() < 2)});
        check("out_valid8", {127'd0, out_valid8}, {127'd0, (q.size() > 0)});
        check("out_valid128", {127'd0, out_valid128}, {127'd0, (q.size() > 0)});
        check("ready_when_full", {127'd0, (in_ready8 && count8 == 2'd2)}, 128'd0);
        if (q.size() > 0) begin
            check("out_data8", {120'd0, out_data8}, {120'd0, q[0][7:0]});
            check("out_data128", out_data128, q[0]);
        end
    endtask

    // One clock: drive inputs, advance the model by the handshake rules, then
    // sample shortly after the edge.
    task automatic cycle(input logic iv, input logic [127:0] d, input logic ordy,
                         input logic fl, input logic rs);
        logic         stall;
        logic         pop, push;
        logic [7:0]   prev8;
        logic [127:0] prev128;
        stall     = (q.size() > 0) && !ordy && !fl && rs;
        prev8     = out_data8;
        prev128   = out_data128;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        if (!rs || fl) begin
            q.delete();
        end else begin
            pop  = (q.size() > 0) && ordy;
            push = iv && (q.size() < 2);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        @(posedge clk);
        #1;
        check_model();
        if (stall) begin
            check("stall_stable8", {120'd0, out_data8}, {120'd0, prev8});
            check("stall_stable128", out_data128, prev128);
        end
    endtask

    task automatic applyStimulus();
        // Reset
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, rep(8'h55), 1'b1, 1'b0, 1'b0);
        check("rst_data8", {120'd0, out_data8}, 128'd0);
        check("rst_data128", out_data128, 128'd0);

        // Pass-through
        cycle(1'b1, rep(8'hA1), 1'b1, 1'b0, 1'b1);
        check("pt_a1", {120'd0, out_data8}, 128'hA1);
        cycle(1'b1, rep(8'hA2), 1'b1, 1'b0, 1'b1);
        check("pt_a2", {120'd0, out_data8}, 128'hA2);
        cycle(1'b1, rep(8'hA3), 1'b1, 1'b0, 1'b1);
        check("pt_a3", out_data128, rep(8'hA3));
        check("pt_count", {126'd0, count8}, 128'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Backpressure
        cycle(1'b1, rep(8'hB1), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rep(8'hB2), 1'b0, 1'b0, 1'b1);
        check("bp_full", {126'd0, count8}, 128'd2);
        check("bp_ready", {127'd0, in_ready8}, 128'd0);
        cycle(1'b1, rep(8'hB3), 1'b0, 1'b0, 1'b1);
        check("bp_hold_b1", {120'd0, out_data8}, 128'hB1);
        cycle(1'b1, rep(8'hB3), 1'b1, 1'b0, 1'b1);
        check("bp_b2", {120'd0, out_data8}, 128'hB2);
        cycle(1'b1, rep(8'hB3), 1'b1, 1'b0, 1'b1);
        check("bp_b3", {120'd0, out_data8}, 128'hB3);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("bp_empty", {126'd0, count8}, 128'd0);

        // Flush in FULL with simultaneous drain
        cycle(1'b1, rep(8'hC1), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rep(8'hC2), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check("fl_count", {126'd0, count8}, 128'd0);
        check("fl_valid", {127'd0, out_valid8}, 128'd0);
        check("fl_clear8", {120'd0, out_data8}, 128'd0);
        check("fl_keep128", out_data128, rep(8'hC1));

        // Simultaneous fire in ONE
        cycle(1'b1, rep(8'hD1), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rep(8'hD2), 1'b1, 1'b0, 1'b1);
        check("sim_d2", {120'd0, out_data8}, 128'hD2);
        check("sim_count", {126'd0, count8}, 128'd1);

        // Flush in ONE discards the beat accepted in the same cycle
        cycle(1'b1, rep(8'hF2), 1'b0, 1'b1, 1'b1);
        check("fl1_count", {126'd0, count8}, 128'd0);
        cycle(1'b1, rep(8'hF3), 1'b0, 1'b0, 1'b1);
        check("fl1_next", {120'd0, out_data8}, 128'hF3);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Reset mid-operation
        cycle(1'b1, rep(8'hE1), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rep(8'hE2), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rep(8'h77), 1'b1, 1'b1, 1'b0);
        check("mr_count", {126'd0, count8}, 128'd0);
        check("mr_ready", {127'd0, in_ready8}, 128'd1);
        check("mr_data128", out_data128, 128'd0);
        cycle(1'b1, rep(8'hE3), 1'b0, 1'b0, 1'b1);
        check("mr_e3", {120'd0, out_data8}, 128'hE3);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Random stress
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 199) == 0),
                  1'b1);
        end
    endtask

    initial begin
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
